// File: rtl/dds_sweep_ctrl.sv
// Linear frequency-sweep phase sequencer feeding a DDS phase input over AXI-stream.
// Optional feature macro: DDS_SWEEP_LOOP_EN (continuous back-to-back sweeps).
module dds_sweep_ctrl #(
  parameter int unsigned PHASE_DW = 16,
  parameter int unsigned ACC_DW   = 32,
  parameter int unsigned CNT_DW   = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ACC_DW-1:0]   cfg_start_freq,
  input  logic [ACC_DW-1:0]   cfg_step,
  input  logic [CNT_DW-1:0]   cfg_num_steps,
  input  logic [CNT_DW-1:0]   cfg_dwell,
  input  logic                start,
  input  logic                abort,
  output logic                busy,
  output logic                done,
  output logic [PHASE_DW-1:0] m_axis_phase_tdata,
  output logic                m_axis_phase_tvalid,
  input  logic                m_axis_phase_tready,
  output logic                m_axis_phase_tlast
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t              state, state_nxt;
  logic [ACC_DW-1:0]   acc, acc_nxt;
  logic [ACC_DW-1:0]   freq, freq_nxt;
  logic [ACC_DW-1:0]   start_freq_r, start_freq_nxt;
  logic [ACC_DW-1:0]   step_r, step_nxt;
  logic [CNT_DW-1:0]   num_steps_r, num_steps_nxt;
  logic [CNT_DW-1:0]   dwell_r, dwell_nxt;
  logic [CNT_DW-1:0]   dwell_cnt, dwell_cnt_nxt;
  logic [CNT_DW-1:0]   step_cnt, step_cnt_nxt;
  logic                busy_nxt, done_nxt, tvalid_nxt, tlast_nxt;

  logic [CNT_DW-1:0]   num_clamped, dwell_clamped;
  logic [CNT_DW-1:0]   dwell_cnt_adv, step_cnt_adv;
  logic                dwell_end, last_sample, handshake;

  // Zero counts behave as one so a sweep always emits at least one sample.
  assign num_clamped   = (cfg_num_steps == '0) ? CNT_DW'(1) : cfg_num_steps;
  assign dwell_clamped = (cfg_dwell == '0) ? CNT_DW'(1) : cfg_dwell;

  assign dwell_end     = (dwell_cnt == dwell_r - CNT_DW'(1));
  assign last_sample   = dwell_end && (step_cnt == num_steps_r - CNT_DW'(1));
  assign dwell_cnt_adv = dwell_end ? '0 : dwell_cnt + CNT_DW'(1);
  assign step_cnt_adv  = dwell_end ? step_cnt + CNT_DW'(1) : step_cnt;
  assign handshake     = m_axis_phase_tvalid && m_axis_phase_tready;

  assign m_axis_phase_tdata = acc[ACC_DW-1 -: PHASE_DW];

  // Next-state and registered-output decode.
  always_comb begin
    state_nxt      = state;
    acc_nxt        = acc;
    freq_nxt       = freq;
    start_freq_nxt = start_freq_r;
    step_nxt       = step_r;
    num_steps_nxt  = num_steps_r;
    dwell_nxt      = dwell_r;
    dwell_cnt_nxt  = dwell_cnt;
    step_cnt_nxt   = step_cnt;
    busy_nxt       = busy;
    done_nxt       = 1'b0;
    tvalid_nxt     = m_axis_phase_tvalid;
    tlast_nxt      = m_axis_phase_tlast;

    unique case (state)
      IDLE: begin
        if (start && !abort) begin
          state_nxt      = RUN;
          start_freq_nxt = cfg_start_freq;
          step_nxt       = cfg_step;
          num_steps_nxt  = num_clamped;
          dwell_nxt      = dwell_clamped;
          acc_nxt        = '0;
          freq_nxt       = cfg_start_freq;
          dwell_cnt_nxt  = '0;
          step_cnt_nxt   = '0;
          busy_nxt       = 1'b1;
          tvalid_nxt     = 1'b1;
          tlast_nxt      = (num_clamped == CNT_DW'(1)) && (dwell_clamped == CNT_DW'(1));
        end
      end
      RUN: begin
        if (abort) begin
          state_nxt  = IDLE;
          busy_nxt   = 1'b0;
          tvalid_nxt = 1'b0;
          tlast_nxt  = 1'b0;
        end else if (handshake) begin
          if (last_sample) begin
            done_nxt = 1'b1;
`ifdef DDS_SWEEP_LOOP_EN
            // Accumulator keeps running so phase stays continuous across sweeps.
            acc_nxt       = acc + start_freq_r;
            freq_nxt      = start_freq_r;
            dwell_cnt_nxt = '0;
            step_cnt_nxt  = '0;
            tlast_nxt     = (num_steps_r == CNT_DW'(1)) && (dwell_r == CNT_DW'(1));
`else
            acc_nxt    = acc + freq;
            state_nxt  = IDLE;
            busy_nxt   = 1'b0;
            tvalid_nxt = 1'b0;
            tlast_nxt  = 1'b0;
`endif
          end else begin
            acc_nxt       = acc + freq;
            dwell_cnt_nxt = dwell_cnt_adv;
            step_cnt_nxt  = step_cnt_adv;
            if (dwell_end) begin
              freq_nxt = freq + step_r;
            end
            tlast_nxt = (step_cnt_adv == num_steps_r - CNT_DW'(1)) &&
                        (dwell_cnt_adv == dwell_r - CNT_DW'(1));
          end
        end
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state               <= IDLE;
      acc                 <= '0;
      freq                <= '0;
      start_freq_r        <= '0;
      step_r              <= '0;
      num_steps_r         <= '0;
      dwell_r             <= '0;
      dwell_cnt           <= '0;
      step_cnt            <= '0;
      busy                <= 1'b0;
      done                <= 1'b0;
      m_axis_phase_tvalid <= 1'b0;
      m_axis_phase_tlast  <= 1'b0;
    end else begin
      state               <= state_nxt;
      acc                 <= acc_nxt;
      freq                <= freq_nxt;
      start_freq_r        <= start_freq_nxt;
      step_r              <= step_nxt;
      num_steps_r         <= num_steps_nxt;
      dwell_r             <= dwell_nxt;
      dwell_cnt           <= dwell_cnt_nxt;
      step_cnt            <= step_cnt_nxt;
      busy                <= busy_nxt;
      done                <= done_nxt;
      m_axis_phase_tvalid <= tvalid_nxt;
      m_axis_phase_tlast  <= tlast_nxt;
    end
  end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Self-checking bench for dds_sweep_ctrl: directed and random sweeps against a list-based phase model.
// Exercises continuous-sweep behaviour when DDS_SWEEP_LOOP_EN is defined.
module tb_dds_sweep_ctrl;
  localparam int unsigned PW = 16;
  localparam int unsigned AW = 16;
  localparam int unsigned CW = 16;
  localparam int          MAX_CYC = 400;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] cfg_start_freq, cfg_step;
  logic [CW-1:0] cfg_num_steps, cfg_dwell;
  logic          start, abort, busy, done;
  logic [PW-1:0] tdata;
  logic          tvalid, tready, tlast;

  int tests  = 0;
  int errors = 0;

  logic [15:0] exp_ph[$];
  bit          exp_last[$];

  dds_sweep_ctrl #(.PHASE_DW(PW), .ACC_DW(AW), .CNT_DW(CW)) dut (
    .clk                 (clk),
    .reset               (reset),
    .cfg_start_freq      (cfg_start_freq),
    .cfg_step            (cfg_step),
    .cfg_num_steps       (cfg_num_steps),
    .cfg_dwell           (cfg_dwell),
    .start               (start),
    .abort               (abort),
    .busy                (busy),
    .done                (done),
    .m_axis_phase_tdata  (tdata),
    .m_axis_phase_tvalid (tvalid),
    .m_axis_phase_tready (tready),
    .m_axis_phase_tlast  (tlast)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected phase list: sample k of step s sits at the running sum of all earlier frequencies.
  function automatic void build(input logic [15:0] sf, input logic [15:0] st,
                                input int ns, input int dw, input int sweeps);
    logic [15:0] acc;
    logic [15:0] freq;
    int nsc;
    int dwc;
    bit last;
    nsc = (ns == 0) ? 1 : ns;
    dwc = (dw == 0) ? 1 : dw;
    exp_ph.delete();
    exp_last.delete();
    acc = 16'h0;
    for (int w = 0; w < sweeps; w++) begin
      freq = sf;
      for (int s = 0; s < nsc; s++) begin
        for (int d = 0; d < dwc; d++) begin
          last = (s == nsc - 1) && (d == dwc - 1);
          exp_ph.push_back(acc);
          exp_last.push_back(last);
          if (last && sweeps > 1) acc = acc + sf;
          else                    acc = acc + freq;
        end
        freq = freq + st;
      end
    end
  endfunction

  task automatic launch(input logic [15:0] sf, input logic [15:0] st, input int ns, input int dw);
    cfg_start_freq = sf;
    cfg_step       = st;
    cfg_num_steps  = CW'(ns);
    cfg_dwell      = CW'(dw);
    start          = 1'b1;
    @(posedge clk); #1;
    start          = 1'b0;
    cfg_start_freq = AW'($urandom);
    cfg_step       = AW'($urandom);
    cfg_num_steps  = CW'($urandom_range(0, 7));
    cfg_dwell      = CW'($urandom_range(0, 7));
  endtask

  // mode 0: tready high, 1: pattern 1,0,0, 2: random. Ends in the done cycle.
  task automatic sweep(input logic [15:0] sf, input logic [15:0] st, input int ns, input int dw,
                       input int mode, input bit inject);
    int n;
    int idx;
    int cyc;
    int busy_cycles;
    bit hs;
    build(sf, st, ns, dw, 1);
    n = exp_ph.size();
    launch(sf, st, ns, dw);
    idx = 0;
    cyc = 0;
    busy_cycles = 0;
    while (idx < n && cyc < MAX_CYC) begin
      check("tvalid", 32'(tvalid), 32'd1);
      check("busy", 32'(busy), 32'd1);
      check("tdata", 32'(tdata), 32'(exp_ph[idx]));
      check("tlast", 32'(tlast), 32'(exp_last[idx]));
      check("done_mid", 32'(done), 32'd0);
      busy_cycles += int'(busy);
      case (mode)
        0:       tready = 1'b1;
        1:       tready = (cyc % 3 == 0);
        default: tready = 1'($urandom_range(0, 1));
      endcase
      start = inject && (cyc == 2);
      hs = tready;
      @(posedge clk); #1;
      start = 1'b0;
      if (hs) idx++;
      cyc++;
    end
    check("sweep_timeout", 32'(cyc < MAX_CYC), 32'd1);
    check("end_busy", 32'(busy), 32'd0);
    check("end_tvalid", 32'(tvalid), 32'd0);
    check("end_done", 32'(done), 32'd1);
    if (mode == 0) check("busy_cycles", 32'(busy_cycles), 32'(n));
    tready = 1'b1;
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    tready = 1'b1;
    cfg_start_freq = '0;
    cfg_step = '0;
    cfg_num_steps = '0;
    cfg_dwell = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_tvalid", 32'(tvalid), 32'd0);
    check("rst_tlast", 32'(tlast), 32'd0);
    check("rst_tdata", 32'(tdata), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("idle_busy", 32'(busy), 32'd0);

    // Basic sweep, then a back-to-back start in the done cycle with backpressure.
    sweep(16'h1000, 16'h0100, 3, 2, 0, 1'b0);
    sweep(16'h1000, 16'h0100, 3, 2, 1, 1'b0);
    @(posedge clk); #1;
    check("done_clear", 32'(done), 32'd0);

    // Wrap and zero-count clamp.
    sweep(16'h8000, 16'h0000, 0, 4, 0, 1'b0);
    @(posedge clk); #1;

    // Abort on the third sample while it is stalled.
    build(16'h1000, 16'h0100, 3, 2, 1);
    launch(16'h1000, 16'h0100, 3, 2);
    tready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("abort_pre_tdata", 32'(tdata), 32'(exp_ph[2]));
    tready = 1'b0;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_tvalid", 32'(tvalid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    @(posedge clk); #1;
    check("abort_done2", 32'(done), 32'd0);
    tready = 1'b1;
    sweep(16'h1000, 16'h0100, 3, 2, 0, 1'b0);
    @(posedge clk); #1;

    // start and abort together in IDLE.
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    check("collide_busy", 32'(busy), 32'd0);
    check("collide_tvalid", 32'(tvalid), 32'd0);

    // Random configs, random backpressure, stray start during RUN.
    for (int i = 0; i < 20; i++) begin
      sweep(16'($urandom), 16'($urandom), int'($urandom_range(0, 4)),
            int'($urandom_range(0, 3)), 2, 1'b1);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    // Reset mid-sweep.
    @(posedge clk); #1;
    launch(16'h1234, 16'h0010, 4, 4);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midrst_tvalid", 32'(tvalid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_tdata", 32'(tdata), 32'd0);

`ifdef DDS_SWEEP_LOOP_EN
    // Continuous sweeps: done at every boundary, abort leaves RUN.
    build(16'h1000, 16'h0100, 3, 2, 3);
    tready = 1'b1;
    launch(16'h1000, 16'h0100, 3, 2);
    for (int k = 0; k < 18; k++) begin
      check("loop_tvalid", 32'(tvalid), 32'd1);
      check("loop_tdata", 32'(tdata), 32'(exp_ph[k]));
      check("loop_tlast", 32'(tlast), 32'(exp_last[k]));
      check("loop_done", 32'(done), 32'(k > 0 && k % 6 == 0));
      @(posedge clk); #1;
    end
    check("loop_done_end", 32'(done), 32'd1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("loop_abort_tvalid", 32'(tvalid), 32'd0);
    check("loop_abort_busy", 32'(busy), 32'd0);
    check("loop_abort_done", 32'(done), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule
